// File: rtl/hdmi_timing_pkg.sv
// 640x480@60 timing constants and pixel types for the HDMI test source.
// Shared by the timing generator and the pattern top level.
package hdmi_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int BORDER   = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/hdmi_timing_gen.sv
// Pixel-clock divider, X/Y/frame counters and sync/draw-area decode.
// HDMI_PATTERN_ANIM_EN builds the frame counter; otherwise it reads 0.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int HActive = H_ACTIVE,
  parameter int HFp     = H_FP,
  parameter int HSync   = H_SYNC,
  parameter int HBp     = H_BP,
  parameter int VActive = V_ACTIVE,
  parameter int VFp     = V_FP,
  parameter int VSync   = V_SYNC,
  parameter int VBp     = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixClk,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic [9:0] frameCnt,
  output logic       hSync,
  output logic       vSync,
  output logic       drawArea
);

  localparam logic [9:0] HLast  = 10'(HActive + HFp + HSync + HBp - 1);
  localparam logic [9:0] VLast  = 10'(VActive + VFp + VSync + VBp - 1);
  localparam logic [9:0] HAct   = 10'(HActive);
  localparam logic [9:0] VAct   = 10'(VActive);
  localparam logic [9:0] HsLo   = 10'(HActive + HFp);
  localparam logic [9:0] HsHi   = 10'(HActive + HFp + HSync - 1);
  localparam logic [9:0] VsLo   = 10'(VActive + VFp);
  localparam logic [9:0] VsHi   = 10'(VActive + VFp + VSync - 1);

  logic pixEn;
  logic lineEnd;
  logic frameEnd;

  assign pixEn    = ~pixClk;
  assign lineEnd  = counterX == HLast;
  assign frameEnd = lineEnd && (counterY == VLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      pixClk   <= 1'b0;
      counterX <= '0;
      counterY <= '0;
    end else begin
      pixClk <= ~pixClk;
      if (pixEn) begin
        if (lineEnd) begin
          counterX <= '0;
          counterY <= frameEnd ? '0 : counterY + 10'd1;
        end else begin
          counterX <= counterX + 10'd1;
        end
      end
    end
  end

`ifdef HDMI_PATTERN_ANIM_EN
  always_ff @(posedge clk) begin
    if (rst)
      frameCnt <= '0;
    else if (pixEn && frameEnd)
      frameCnt <= frameCnt + 10'd1;
  end
`else
  assign frameCnt = '0;
`endif

  assign drawArea = (counterX < HAct) && (counterY < VAct);
  assign hSync    = (counterX >= HsLo) && (counterX <= HsHi);
  assign vSync    = (counterY >= VsLo) && (counterY <= VsHi);

endmodule

// File: rtl/hdmi_test_pattern.sv
// 640x480 test-pattern source: timing generator plus bordered colour ramp.
// HDMI_PATTERN_ANIM_EN scrolls the red channel with the frame counter.
module hdmi_test_pattern
  import hdmi_timing_pkg::*;
#(
  parameter int HActive = H_ACTIVE,
  parameter int HFp     = H_FP,
  parameter int HSync   = H_SYNC,
  parameter int HBp     = H_BP,
  parameter int VActive = V_ACTIVE,
  parameter int VFp     = V_FP,
  parameter int VSync   = V_SYNC,
  parameter int VBp     = V_BP,
  parameter int Border  = BORDER
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixclk,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic [9:0] CounterX_o,
  output logic [9:0] CounterY_o,
  output logic [9:0] Counter_o,
  output logic       hSync_o,
  output logic       vSync_o,
  output logic       DrawArea_o
);

  localparam logic [9:0] BLo = 10'(Border);
  localparam logic [9:0] BX  = 10'(HActive - Border);
  localparam logic [9:0] BY  = 10'(VActive - Border);

  logic [9:0] cx;
  logic [9:0] cy;
  logic [9:0] frameCnt;
  logic       drawArea;
  logic       inBorder;
  rgb888_t    pix;

  hdmi_timing_gen #(
    .HActive (HActive),
    .HFp     (HFp),
    .HSync   (HSync),
    .HBp     (HBp),
    .VActive (VActive),
    .VFp     (VFp),
    .VSync   (VSync),
    .VBp     (VBp)
  ) uTiming (
    .clk      (clk),
    .rst      (rst),
    .pixClk   (pixclk),
    .counterX (cx),
    .counterY (cy),
    .frameCnt (frameCnt),
    .hSync    (hSync_o),
    .vSync    (vSync_o),
    .drawArea (drawArea)
  );

  assign inBorder = (cx < BLo) || (cx >= BX) ||
                    (cy < BLo) || (cy >= BY);

  always_comb begin
    pix = '0;
    if (drawArea && !inBorder) begin
      pix.r = cx[7:0] + frameCnt[7:0];
      pix.g = cy[7:0];
      pix.b = cx[7:0] ^ cy[7:0];
    end
  end

  assign red_o      = pix.r;
  assign green_o    = pix.g;
  assign blue_o     = pix.b;
  assign CounterX_o = cx;
  assign CounterY_o = cy;
  assign Counter_o  = frameCnt;
  assign DrawArea_o = drawArea;

endmodule

// File: tb/tb_hdmi_test_pattern.sv
// Directed bench: full-size instance for scan/pattern/reset, reduced
// instance (60x28 frame) for frame wrap, vsync and frame-counter checks.
module tb_hdmi_test_pattern;

`ifdef HDMI_PATTERN_ANIM_EN
  localparam int ANIM = 1;
`else
  localparam int ANIM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstS = 1'b1;

  logic       pclk, pclkS;
  logic [7:0] r, g, b, rS, gS, bS;
  logic [9:0] x, y, c, xS, yS, cS;
  logic       hs, vs, da, hsS, vsS, daS;

  int vecs = 0;
  int errs = 0;
  int edges = 0;
  int edgesS = 0;

  always #5 clk = ~clk;

  hdmi_test_pattern dut (
    .clk(clk), .rst(rst), .pixclk(pclk),
    .red_o(r), .green_o(g), .blue_o(b),
    .CounterX_o(x), .CounterY_o(y), .Counter_o(c),
    .hSync_o(hs), .vSync_o(vs), .DrawArea_o(da)
  );

  hdmi_test_pattern #(
    .HActive(40), .HFp(4), .HSync(8), .HBp(8),
    .VActive(20), .VFp(2), .VSync(2), .VBp(4),
    .Border(4)
  ) dutS (
    .clk(clk), .rst(rstS), .pixclk(pclkS),
    .red_o(rS), .green_o(gS), .blue_o(bS),
    .CounterX_o(xS), .CounterY_o(yS), .Counter_o(cS),
    .hSync_o(hsS), .vSync_o(vsS), .DrawArea_o(daS)
  );

  // pixel n of frame 0 first appears after clk edge 2n-1
  task automatic goPix(input int px, input int py);
    int tgt;
    tgt = 2 * (py * 800 + px) - 1;
    repeat (tgt - edges) @(negedge clk);
    edges = tgt;
  endtask

  task automatic goPixS(input int f, input int px, input int py);
    int tgt;
    tgt = 2 * (f * 1680 + py * 60 + px) - 1;
    repeat (tgt - edgesS) @(negedge clk);
    edgesS = tgt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({pclk, x, y, c} !== {1'b0, 10'd0, 10'd0, 10'd0}) begin
      $display("FAIL reset_regs got pclk=%0d x=%0d y=%0d c=%0d want 0",
               pclk, x, y, c);
      errs++;
    end
    vecs++;
    if ({da, r, g, b} !== {1'b1, 24'd0}) begin
      $display("FAIL reset_pix got da=%0d rgb=%h want da=1 rgb=000000",
               da, {r, g, b});
      errs++;
    end
    rst = 1'b0;
    edges = 0;
    @(negedge clk);
    edges++;
    vecs++;
    if ({pclk, x} !== {1'b1, 10'd1}) begin
      $display("FAIL first_edge got pclk=%0d x=%0d want 1 1", pclk, x);
      errs++;
    end
    @(negedge clk);
    edges++;
    vecs++;
    if ({pclk, x, y} !== {1'b0, 10'd1, 10'd0}) begin
      $display("FAIL second_edge got pclk=%0d x=%0d y=%0d want 0 1 0",
               pclk, x, y);
      errs++;
    end
  endtask

  task automatic test_line0;
    goPix(639, 0);
    vecs++;
    if ({x, da, hs, vs} !== {10'd639, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL x639 got x=%0d da=%0d hs=%0d vs=%0d want 639 1 0 0",
               x, da, hs, vs);
      errs++;
    end
    goPix(640, 0);
    vecs++;
    if ({x, da, r, g, b} !== {10'd640, 1'b0, 24'd0}) begin
      $display("FAIL x640 got x=%0d da=%0d rgb=%h want 640 0 000000",
               x, da, {r, g, b});
      errs++;
    end
    goPix(655, 0);
    vecs++;
    if ({x, hs} !== {10'd655, 1'b0}) begin
      $display("FAIL hs655 got x=%0d hs=%0d want 655 0", x, hs);
      errs++;
    end
    goPix(656, 0);
    vecs++;
    if ({x, hs} !== {10'd656, 1'b1}) begin
      $display("FAIL hs656 got x=%0d hs=%0d want 656 1", x, hs);
      errs++;
    end
    goPix(751, 0);
    vecs++;
    if ({x, hs} !== {10'd751, 1'b1}) begin
      $display("FAIL hs751 got x=%0d hs=%0d want 751 1", x, hs);
      errs++;
    end
    goPix(752, 0);
    vecs++;
    if ({x, hs} !== {10'd752, 1'b0}) begin
      $display("FAIL hs752 got x=%0d hs=%0d want 752 0", x, hs);
      errs++;
    end
    goPix(0, 1);
    vecs++;
    if ({x, y, da} !== {10'd0, 10'd1, 1'b1}) begin
      $display("FAIL line_wrap got x=%0d y=%0d da=%0d want 0 1 1",
               x, y, da);
      errs++;
    end
  endtask

  task automatic test_pattern;
    goPix(10, 10);
    vecs++;
    if ({x, y, da, r, g, b} !== {10'd10, 10'd10, 1'b1, 24'd0}) begin
      $display("FAIL border_10_10 got x=%0d y=%0d da=%0d rgb=%h want 10 10 1 000000",
               x, y, da, {r, g, b});
      errs++;
    end
    goPix(100, 16);
    vecs++;
    if ({r, g, b} !== {8'd100, 8'd16, 8'd116}) begin
      $display("FAIL pix_100_16 got rgb=%0d,%0d,%0d want 100,16,116",
               r, g, b);
      errs++;
    end
    goPix(623, 16);
    vecs++;
    if ({r, g, b} !== {8'd111, 8'd16, 8'd127}) begin
      $display("FAIL pix_623_16 got rgb=%0d,%0d,%0d want 111,16,127",
               r, g, b);
      errs++;
    end
    goPix(624, 16);
    vecs++;
    if ({da, r, g, b} !== {1'b1, 24'd0}) begin
      $display("FAIL border_624 got da=%0d rgb=%h want 1 000000",
               da, {r, g, b});
      errs++;
    end
  endtask

  task automatic test_mid_reset;
    goPix(300, 17);
    vecs++;
    if ({x, y, c} !== {10'd300, 10'd17, 10'd0}) begin
      $display("FAIL pre_reset got x=%0d y=%0d c=%0d want 300 17 0",
               x, y, c);
      errs++;
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({pclk, x, y, c} !== {1'b0, 10'd0, 10'd0, 10'd0}) begin
      $display("FAIL mid_reset got pclk=%0d x=%0d y=%0d c=%0d want 0 0 0 0",
               pclk, x, y, c);
      errs++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({x, y} !== {10'd1, 10'd0}) begin
      $display("FAIL post_reset got x=%0d y=%0d want 1 0", x, y);
      errs++;
    end
  endtask

  task automatic test_frame_wrap;
    rstS = 1'b0;
    edgesS = 0;
    goPixS(0, 46, 0);
    vecs++;
    if ({xS, hsS, daS} !== {10'd46, 1'b1, 1'b0}) begin
      $display("FAIL s_hs46 got x=%0d hs=%0d da=%0d want 46 1 0",
               xS, hsS, daS);
      errs++;
    end
    goPixS(0, 0, 21);
    vecs++;
    if ({yS, vsS} !== {10'd21, 1'b0}) begin
      $display("FAIL s_vs21 got y=%0d vs=%0d want 21 0", yS, vsS);
      errs++;
    end
    goPixS(0, 0, 22);
    vecs++;
    if ({yS, vsS} !== {10'd22, 1'b1}) begin
      $display("FAIL s_vs22 got y=%0d vs=%0d want 22 1", yS, vsS);
      errs++;
    end
    goPixS(0, 59, 23);
    vecs++;
    if ({xS, yS, vsS} !== {10'd59, 10'd23, 1'b1}) begin
      $display("FAIL s_vs23 got x=%0d y=%0d vs=%0d want 59 23 1",
               xS, yS, vsS);
      errs++;
    end
    goPixS(0, 0, 24);
    vecs++;
    if ({yS, vsS} !== {10'd24, 1'b0}) begin
      $display("FAIL s_vs24 got y=%0d vs=%0d want 24 0", yS, vsS);
      errs++;
    end
    goPixS(0, 59, 27);
    vecs++;
    if ({xS, yS, cS} !== {10'd59, 10'd27, 10'd0}) begin
      $display("FAIL s_last got x=%0d y=%0d c=%0d want 59 27 0",
               xS, yS, cS);
      errs++;
    end
    goPixS(1, 0, 0);
    vecs++;
    if ({xS, yS, cS, vsS} !== {10'd0, 10'd0, 10'(ANIM), 1'b0}) begin
      $display("FAIL s_wrap got x=%0d y=%0d c=%0d vs=%0d want 0 0 %0d 0",
               xS, yS, cS, vsS, ANIM);
      errs++;
    end
    goPixS(1, 10, 5);
    vecs++;
    if ({rS, gS, bS} !== {8'(10 + ANIM), 8'd5, 8'd15}) begin
      $display("FAIL s_pix_f1 got rgb=%0d,%0d,%0d want %0d,5,15",
               rS, gS, bS, 10 + ANIM);
      errs++;
    end
  endtask

  initial begin
    test_reset;
    test_line0;
    test_pattern;
    test_mid_reset;
    test_frame_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hdmi_test_pattern.md
Name: hdmi_test_pattern

Overview:
- Self-contained 640x480@60 video timing generator and test-pattern source for the HDMI output path.
- Derives a pixel clock from the system clock and scans horizontal and vertical counters.
- Generates sync and draw-area flags and 8-bit RGB pattern data.
- Sits ahead of the TMDS encoders. Its counters are exported so benches can check pixel colours at known coordinates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (frame total 525)
- BORDER, 16, width in pixels of the black frame border inside the visible area

Ports:
- clk  in  1  system clock; all logic rising-edge. One clock domain only.
- rst  in  1  synchronous, active-high reset
- pixclk  out  1  pixel clock, clk/2, registered
- red_o  out  8  red component
- green_o  out  8  green component
- blue_o  out  8  blue component
- CounterX_o  out  10  horizontal position, 0..799
- CounterY_o  out  10  vertical position, 0..524
- Counter_o  out  10  frame counter
- hSync_o  out  1  horizontal sync, active-high
- vSync_o  out  1  vertical sync, active-high
- DrawArea_o  out  1  1 inside the visible 640x480 area

Behaviour:
- Reset: pixclk=0, CounterX=0, CounterY=0, Counter=0. All registers clear on the first clk edge with rst=1. A mid-frame reset restarts at pixel (0,0) on the next edge.
- pixclk register toggles every clk edge when rst=0. pix_en = (pixclk==0), so counters advance on the same edge where pixclk rises. Each pixel lasts 2 clk cycles.
- On pix_en:
  - CounterX increments.
  - At 799, CounterX wraps to 0 and CounterY increments.
  - When CounterX wraps with CounterY=524, CounterY wraps to 0 and Counter increments.
  - Counter wraps 1023->0.
- The following are combinational from the counter registers, so they describe the same pixel as CounterX_o/CounterY_o (zero latency):
  - DrawArea = (CounterX<640) and (CounterY<480)
  - hSync = 656<=CounterX<=751
  - vSync = 490<=CounterY<=491
- Colours:
  - Outside the draw area, RGB=0.
  - Inside the draw area but within BORDER pixels of any visible edge (X<16, X>=624, Y<16, Y>=464), RGB=0 (black).
  - Elsewhere: red = CounterX[7:0]+Counter[7:0] (mod 256); green = CounterY[7:0]; blue = CounterX[7:0] XOR CounterY[7:0].
- Timing constants are derived from parameters. All counter widths are 10 bits, and parameter totals must be <=1024.

Optional Feature:
- Macro: HDMI_PATTERN_ANIM_EN.
- Defined: Counter increments per frame as above, and the red channel scrolls with it.
- Undefined: the frame-counter register is not built, Counter_o is tied to 0, and red = CounterX[7:0].

Decomposition:
- Shared package hdmi_timing_pkg holds:
  - the 640x480 timing constants (active/porch/sync values, totals 800/525)
  - the border width
  - an rgb888 struct typedef
- One natural sub-module, hdmi_timing_gen: pixclk divider, X/Y/frame counters, sync and draw-area decode.
- The top level adds the colour-pattern logic.

Test Plan:
- Reset held 3 cycles, then released -> pixclk=0, X=Y=Counter=0, DrawArea=1, RGB=0 (border). X=1 after 2 clk edges.
- Scan to (10,10) -> DrawArea=1, red=green=blue=0.
- Scan to (100,50), frame 0 -> red=100, green=50, blue=100^50=86.
- Scan line 0 -> hSync rises at X=656 and falls at X=752. DrawArea falls at X=640.
- End of frame: (799,524) -> next pixel is (0,0), Counter=1, vSync high only on Y=490..491. With the macro undefined, Counter stays 0.
- Assert rst at (300,200) -> next edge X=Y=Counter=0, pixclk=0.
